// File: rtl/pc_if_pkg.sv
// Shared types for the program-counter load interface: address/byte types,
// jump sequencer states, strobe polarity and the sequencer debug view.
package pc_if_pkg;

    localparam int PC_ADDR_W = 16;
    localparam int PC_DATA_W = 8;

    typedef logic [PC_ADDR_W-1:0] pc_addr_t;
    typedef logic [PC_DATA_W-1:0] pc_byte_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_HI = 2'd1,
        LOAD_LO = 2'd2,
        VERIFY  = 2'd3
    } jump_state_e;

    localparam logic STROBE_ACTIVE = 1'b0;
    localparam logic STROBE_IDLE   = 1'b1;

    typedef struct packed {
        jump_state_e state;
        logic        skip_hi;
        logic        cache_valid;
        pc_byte_t    cache_hi;
    } jump_dbg_t;

    // True when PCHITMP already holds the wanted high byte.
    function automatic logic hi_cache_hit(input logic     valid,
                                          input pc_byte_t cached,
                                          input pc_byte_t wanted);
        return valid && (cached == wanted);
    endfunction

endpackage

// File: rtl/pc_jump_driver.sv
// Jump sequencer: takes a target over ready/valid, drives the PC load strobes
// and D bus one step per cycle, then confirms PCHI/PCLO landed on the target.
module pc_jump_driver
    import pc_if_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int HITMP_CACHE = 1
) (
    input  logic              clk,
    input  logic              MR,
    input  logic              jmp_valid,
    output logic              jmp_ready,
    input  logic [ADDR_W-1:0] jmp_addr,
    input  logic              jmp_short,
    output logic              _pchitmp_in,
    output logic              _pc_in,
    output logic              _pclo_in,
    output logic [DATA_W-1:0] D,
    output logic              D_oe,
    input  logic [DATA_W-1:0] PCHI,
    input  logic [DATA_W-1:0] PCLO,
    output logic              done,
    output logic              err,
    output jump_dbg_t         dbg
);

    // Valid/ready: a request is taken at a rising edge where jmp_valid and
    // jmp_ready are both 1; jmp_ready is 1 exactly while the FSM is in IDLE,
    // and jmp_addr/jmp_short are don't-care at every other edge.

    jump_state_e state_q, state_d;
    pc_addr_t    addr_q, addr_d;
    logic        short_q, short_d;
    logic        skip_q, skip_d;
    pc_byte_t    cache_hi_q, cache_hi_d;
    logic        cache_valid_q, cache_valid_d;

    logic        jmp_ready_q, jmp_ready_d;
    logic        pchitmp_n_q, pchitmp_n_d;
    logic        pc_n_q, pc_n_d;
    logic        pclo_n_q, pclo_n_d;
    pc_byte_t    d_q, d_d;
    logic        d_oe_q, d_oe_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        accept;
    logic        skip_hi;
    logic        mismatch;

    always_comb begin : next_state_logic
        accept   = jmp_valid && jmp_ready_q;
        skip_hi  = (HITMP_CACHE != 0) &&
                   hi_cache_hit(cache_valid_q, cache_hi_q, jmp_addr[ADDR_W-1:DATA_W]);
        mismatch = short_q ? (PCLO != addr_q[DATA_W-1:0])
                           : ({PCHI, PCLO} != addr_q);

        state_d       = state_q;
        addr_d        = addr_q;
        short_d       = short_q;
        skip_d        = skip_q;
        cache_hi_d    = cache_hi_q;
        cache_valid_d = cache_valid_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = jmp_addr;
                    short_d = jmp_short;
                    skip_d  = skip_hi;
                    state_d = (jmp_short || skip_hi) ? LOAD_LO : LOAD_HI;
                end
            end
            LOAD_HI: begin
                // PCHITMP takes the byte on this edge, so it is now known.
                cache_hi_d    = addr_q[ADDR_W-1:DATA_W];
                cache_valid_d = 1'b1;
                state_d       = LOAD_LO;
            end
            LOAD_LO: state_d = VERIFY;
            VERIFY:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they line up with it
    // after the edge, keeping the strobes free of input-to-output paths.
    always_comb begin : next_output_logic
        jmp_ready_d = (state_d == IDLE);
        pchitmp_n_d = STROBE_IDLE;
        pc_n_d      = STROBE_IDLE;
        pclo_n_d    = STROBE_IDLE;
        d_d         = '0;
        d_oe_d      = 1'b0;
        done_d      = (state_q == VERIFY);
        err_d       = (state_q == VERIFY) && mismatch;

        case (state_d)
            LOAD_HI: begin
                pchitmp_n_d = STROBE_ACTIVE;
                d_d         = addr_d[ADDR_W-1:DATA_W];
                d_oe_d      = 1'b1;
            end
            LOAD_LO: begin
                if (short_d) begin
                    pclo_n_d = STROBE_ACTIVE;
                end else begin
                    pc_n_d = STROBE_ACTIVE;
                end
                d_d    = addr_d[DATA_W-1:0];
                d_oe_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (MR) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            short_q       <= 1'b0;
            skip_q        <= 1'b0;
            cache_hi_q    <= '0;
            cache_valid_q <= 1'b0;
            jmp_ready_q   <= 1'b1;
            pchitmp_n_q   <= STROBE_IDLE;
            pc_n_q        <= STROBE_IDLE;
            pclo_n_q      <= STROBE_IDLE;
            d_q           <= '0;
            d_oe_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            short_q       <= short_d;
            skip_q        <= skip_d;
            cache_hi_q    <= cache_hi_d;
            cache_valid_q <= cache_valid_d;
            jmp_ready_q   <= jmp_ready_d;
            pchitmp_n_q   <= pchitmp_n_d;
            pc_n_q        <= pc_n_d;
            pclo_n_q      <= pclo_n_d;
            d_q           <= d_d;
            d_oe_q        <= d_oe_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign jmp_ready   = jmp_ready_q;
    assign _pchitmp_in = pchitmp_n_q;
    assign _pc_in      = pc_n_q;
    assign _pclo_in    = pclo_n_q;
    assign D           = d_q;
    assign D_oe        = d_oe_q;
    assign done        = done_q;
    assign err         = err_q;

    assign dbg.state       = state_q;
    assign dbg.skip_hi     = skip_q;
    assign dbg.cache_valid = cache_valid_q;
    assign dbg.cache_hi    = cache_hi_q;

endmodule

// File: doc/pc_jump_driver.md
Name: pc_jump_driver

Overview:
- Initiator side of the program-counter load interface.
- Accepts a 16-bit jump target over a ready/valid handshake.
- Sequences the PC's active-low load strobes (_pchitmp_in, _pc_in, _pclo_in) and the shared 8-bit D bus, then checks PCHI/PCLO to confirm the PC landed on the target.
- Sits between the control decoder and the pc block; it is the only driver of the PC load strobes.

Parameters:
- ADDR_W, 16, jump target width; fixed at 2x DATA_W.
- DATA_W, 8, D bus and PC half width.
- HITMP_CACHE, 1, when 1, skip the PCHITMP load if the target high byte equals the last byte this block wrote to PCHITMP.

Ports:
- clk  in  1  system clock; all state and registered outputs update on the +ve edge.
- MR  in  1  synchronous master reset, active-high.
- jmp_valid  in  1  jump request valid.
- jmp_ready  out  1  request accepted when valid && ready at a +ve edge.
- jmp_addr  in  16  target address {hi,lo}.
- jmp_short  in  1  same-page jump: load PCLO only, PCHI is untouched.
- _pchitmp_in  out  1  active-low strobe: PCHITMP <= D.
- _pc_in  out  1  active-low strobe: PCHI <= PCHITMP, PCLO <= D.
- _pclo_in  out  1  active-low strobe: PCLO <= D.
- D  out  8  data to the PC.
- D_oe  out  1  bus drive enable; high only while a strobe is low.
- PCHI  in  8  current PC high byte.
- PCLO  in  8  current PC low byte.
- done  out  1  one-cycle pulse at the end of every jump.
- err  out  1  valid with done; 1 means the PC did not equal the target.

Behaviour:
- Reset (MR=1 at an edge):
  - state=IDLE, jmp_ready=1 in the following cycle.
  - All strobes=1, D=0x00, D_oe=0, done=0, err=0.
  - Cache invalid; any in-flight sequence is abandoned.
  - MR takes priority over every other input.
- Outputs are registered, so no combinational path from inputs to strobes.
- At most one strobe is low in any cycle.
- jmp_ready=1 only in IDLE. On acceptance, latch addr, short and the skip decision.
- skip_hi = HITMP_CACHE && cache_valid && addr[15:8]==cache_hi.
- States:
  - IDLE: on accept, go to LOAD_LO if short or skip_hi, else LOAD_HI.
  - LOAD_HI (1 cycle): _pchitmp_in=0, D=addr[15:8], D_oe=1. Next edge: cache_hi=addr[15:8], cache_valid=1, go to LOAD_LO.
  - LOAD_LO (1 cycle): D=addr[7:0], D_oe=1. Strobe is _pclo_in=0 if short, else _pc_in=0. Go to VERIFY.
  - VERIFY (1 cycle): all strobes high, D_oe=0.
    - Compare {PCHI,PCLO} to addr, or PCLO only when short.
    - Register done=1 and err=mismatch; both are visible in the next cycle.
    - Go to IDLE.
- Latency, accept edge to done high:
  - Long jump: 4 edges.
  - Short or cached jump: 3 edges.
- Back-to-back: jmp_ready returns in the same cycle done is high, so a new request can be accepted on that edge. Throughput is 1 jump per 4 or 3 cycles.
- The PC free-runs (increments) in every cycle without a strobe, including VERIFY+1. The compare is taken only in VERIFY.
- Target 0xFFFF and 0x0000 are legal. Wrap-around after a jump is the PC's concern.
- jmp_addr is ignored unless valid && ready. A request held during busy is accepted on the first ready edge.

Decomposition:
- Shared package pc_if_pkg:
  - typedef pc_addr_t (16 bits) and pc_byte_t (8 bits).
  - enum jump_state_e {IDLE, LOAD_HI, LOAD_LO, VERIFY}.
  - STROBE_ACTIVE=1'b0.
- No sub-module: one FSM with an output register stage, sized at roughly 150-250 lines.

Test Plan:
1. Reset: MR=1 for 2 edges mid LOAD_HI of a jump to 0x1234 -> next cycle all strobes=1, D_oe=0, jmp_ready=1, done=0; PC stays 0x0000 (pc _MR tied to !MR).
2. Long jump: after reset, request 0xFF AA -> LOAD_HI cycle D=0xFF with _pchitmp_in=0; LOAD_LO cycle D=0xAA with _pc_in=0; {PCHI,PCLO}=0xFFAA in VERIFY; done=1, err=0 four edges after accept; next edge PC=0xFFAB.
3. Cached jump: next request 0xFF10 -> no LOAD_HI, _pc_in=0 with D=0x10; done after 3 edges, PC=0xFF10. Then request 0x0110 -> LOAD_HI is issued again.
4. Short jump: PC at 0xFF12, request 0x00FE with short=1 -> _pclo_in=0, D=0xFE; PCHI stays 0xFF, PCLO=0xFE, err=0. Next increment gives 0xFFFF, then wraps to 0x0000.
5. Mismatch: bench holds the PC model's loads disabled and issues a jump to 0x1234 -> done=1, err=1; jmp_ready=1 in that same cycle.
6. Back-to-back: jmp_valid held high with 0x0100 then 0x0200 -> second accept on the done edge, strobes never overlap, both complete with err=0.
